// File: rtl/mgmt_wb_target_sequencer.sv
// Routes each management-core Wishbone cycle to either the user project or
// housekeeping target, with registered outputs, a wait timeout and abort handling.
module mgmt_wb_target_sequencer #(
    parameter logic [31:0] MPRJ_BASE = 32'h3000_0000,
    parameter logic [31:0] MPRJ_MASK = 32'hF000_0000,
    parameter logic [31:0] HK_BASE   = 32'h2600_0000,
    parameter logic [31:0] HK_MASK   = 32'hFF00_0000,
    parameter int          TIMEOUT   = 255,
    parameter int          TO_W      = 8,
    parameter logic [31:0] ERR_DATA  = 32'hBADD_1E55
) (
    input  logic        core_clk,
    input  logic        core_rst,
    input  logic        m_cyc_i,
    input  logic        m_stb_i,
    input  logic        m_we_i,
    input  logic [3:0]  m_sel_i,
    input  logic [31:0] m_adr_i,
    input  logic [31:0] m_dat_i,
    output logic        m_ack_o,
    output logic        m_err_o,
    output logic [31:0] m_dat_o,
    input  logic        mprj_wb_iena,
    output logic        mprj_cyc_o,
    output logic        mprj_stb_o,
    output logic        mprj_we_o,
    output logic [3:0]  mprj_sel_o,
    output logic [31:0] mprj_adr_o,
    output logic [31:0] mprj_dat_o,
    input  logic        mprj_ack_i,
    input  logic [31:0] mprj_dat_i,
    output logic        hk_cyc_o,
    output logic        hk_stb_o,
    input  logic        hk_ack_i,
    input  logic [31:0] hk_dat_i,
    output logic        busy_o,
    output logic        timeout_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MPRJ,
        ST_HK,
        ST_RESP
    } state_t;

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);

    state_t            state;
    state_t            state_nxt;
    logic [TO_W-1:0]   to_cnt;
    logic [TO_W-1:0]   to_cnt_nxt;

    logic              request;
    logic              mprj_hit;
    logic              hk_hit;
    logic              tgt_ack;
    logic [31:0]       tgt_dat;

    logic              bus_ld;
    logic              ack_nxt;
    logic              err_nxt;
    logic              timeout_nxt;
    logic [31:0]       dat_nxt;

    assign request  = m_cyc_i & m_stb_i & ~m_ack_o & ~m_err_o;
    assign mprj_hit = (m_adr_i & MPRJ_MASK) == MPRJ_BASE;
    assign hk_hit   = (m_adr_i & HK_MASK) == HK_BASE;

    // Only the target owning the current wait state is listened to.
    assign tgt_ack  = (state == ST_MPRJ) ? mprj_ack_i : hk_ack_i;
    assign tgt_dat  = (state == ST_MPRJ) ? mprj_dat_i : hk_dat_i;

    always_comb begin
        state_nxt   = state;
        to_cnt_nxt  = to_cnt;
        bus_ld      = 1'b0;
        ack_nxt     = 1'b0;
        err_nxt     = 1'b0;
        timeout_nxt = 1'b0;
        dat_nxt     = '0;

        case (state)
            ST_IDLE: begin
                if (request) begin
                    if (mprj_hit && mprj_wb_iena) begin
                        state_nxt  = ST_MPRJ;
                        bus_ld     = 1'b1;
                        to_cnt_nxt = '0;
                    end else if (!mprj_hit && hk_hit) begin
                        state_nxt  = ST_HK;
                        bus_ld     = 1'b1;
                        to_cnt_nxt = '0;
                    end else begin
                        // Gated user-project access and unmapped addresses fail fast.
                        state_nxt = ST_RESP;
                        err_nxt   = 1'b1;
                        dat_nxt   = ERR_DATA;
                    end
                end
            end

            ST_MPRJ, ST_HK: begin
                // Abort beats a same-cycle ack; an ack beats the terminal count.
                if (!m_cyc_i) begin
                    state_nxt = ST_IDLE;
                end else if (tgt_ack) begin
                    state_nxt = ST_RESP;
                    ack_nxt   = 1'b1;
                    dat_nxt   = tgt_dat;
                end else if (to_cnt == TO_LIMIT) begin
                    state_nxt   = ST_RESP;
                    err_nxt     = 1'b1;
                    timeout_nxt = 1'b1;
                    dat_nxt     = ERR_DATA;
                end else begin
                    to_cnt_nxt = to_cnt + TO_W'(1);
                end
            end

            ST_RESP: begin
                state_nxt = ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            state  <= ST_IDLE;
            to_cnt <= '0;
        end else begin
            state  <= state_nxt;
            to_cnt <= to_cnt_nxt;
        end
    end

    // Every output is a flop so neither side sees combinational paths through here.
    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            m_ack_o    <= 1'b0;
            m_err_o    <= 1'b0;
            m_dat_o    <= '0;
            mprj_cyc_o <= 1'b0;
            mprj_stb_o <= 1'b0;
            hk_cyc_o   <= 1'b0;
            hk_stb_o   <= 1'b0;
            busy_o     <= 1'b0;
            timeout_o  <= 1'b0;
            mprj_we_o  <= 1'b0;
            mprj_sel_o <= '0;
            mprj_adr_o <= '0;
            mprj_dat_o <= '0;
        end else begin
            m_ack_o    <= ack_nxt;
            m_err_o    <= err_nxt;
            m_dat_o    <= dat_nxt;
            mprj_cyc_o <= (state_nxt == ST_MPRJ);
            mprj_stb_o <= (state_nxt == ST_MPRJ);
            hk_cyc_o   <= (state_nxt == ST_HK);
            hk_stb_o   <= (state_nxt == ST_HK);
            busy_o     <= (state_nxt != ST_IDLE);
            timeout_o  <= timeout_nxt;
            if (bus_ld) begin
                mprj_we_o  <= m_we_i;
                mprj_sel_o <= m_sel_i;
                mprj_adr_o <= m_adr_i;
                mprj_dat_o <= m_dat_i;
            end
        end
    end

endmodule

// File: tb/tb_mgmt_wb_target_sequencer.sv
// Bench for mgmt_wb_target_sequencer: directed scenarios plus random transactions,
// each transaction's outcome derived from its event times (ack/abort/reset/timeout).
module tb_mgmt_wb_target_sequencer;

    localparam int          TO   = 4;
    localparam int          NONE = 1000;
    localparam logic [31:0] ERRD = 32'hBADD_1E55;

    logic        clk = 1'b0;
    logic        rst;
    logic        m_cyc, m_stb, m_we;
    logic [3:0]  m_sel;
    logic [31:0] m_adr, m_wdat;
    logic        m_ack_o, m_err_o;
    logic [31:0] m_dat_o;
    logic        iena;
    logic        mprj_cyc_o, mprj_stb_o, mprj_we_o;
    logic [3:0]  mprj_sel_o;
    logic [31:0] mprj_adr_o, mprj_dat_o;
    logic        mprj_ack;
    logic [31:0] mprj_rdat;
    logic        hk_cyc_o, hk_stb_o;
    logic        hk_ack;
    logic [31:0] hk_rdat;
    logic        busy_o, timeout_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mgmt_wb_target_sequencer #(
        .TIMEOUT(TO),
        .TO_W(8)
    ) dut (
        .core_clk    (clk),
        .core_rst    (rst),
        .m_cyc_i     (m_cyc),
        .m_stb_i     (m_stb),
        .m_we_i      (m_we),
        .m_sel_i     (m_sel),
        .m_adr_i     (m_adr),
        .m_dat_i     (m_wdat),
        .m_ack_o     (m_ack_o),
        .m_err_o     (m_err_o),
        .m_dat_o     (m_dat_o),
        .mprj_wb_iena(iena),
        .mprj_cyc_o  (mprj_cyc_o),
        .mprj_stb_o  (mprj_stb_o),
        .mprj_we_o   (mprj_we_o),
        .mprj_sel_o  (mprj_sel_o),
        .mprj_adr_o  (mprj_adr_o),
        .mprj_dat_o  (mprj_dat_o),
        .mprj_ack_i  (mprj_ack),
        .mprj_dat_i  (mprj_rdat),
        .hk_cyc_o    (hk_cyc_o),
        .hk_stb_o    (hk_stb_o),
        .hk_ack_i    (hk_ack),
        .hk_dat_i    (hk_rdat),
        .busy_o      (busy_o),
        .timeout_o   (timeout_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Target decode of the default address map: 0 = error, 1 = mprj, 2 = hk.
    function automatic int decode(input logic [31:0] adr, input logic ien);
        if (adr[31:28] == 4'h3) return ien ? 1 : 0;
        if (adr[31:24] == 8'h26) return 2;
        return 0;
    endfunction

    // d/a/s are the wait-count values at which the target acks, the master
    // aborts, or reset is applied (NONE = never). hold keeps the request up
    // through the response cycle.
    task automatic run_txn(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                           input logic [3:0] sel, input logic ien, input int d, input int a,
                           input int s, input logic hold, input logic [31:0] rdat);
        int   tgt, kind, end_x, r, last;
        logic stb_ph, resp, cyc_v;
        logic [31:0] md, hd;
        tgt = decode(adr, ien);
        // kind: 0 decode error, 1 ack, 2 timeout, 3 abort, 4 reset
        if (tgt == 0) begin
            kind = 0; end_x = -1;
        end else if (s <= a && s <= d && s <= TO) begin
            kind = 4; end_x = s;
        end else if (a <= d && a <= TO) begin
            kind = 3; end_x = a;
        end else if (d <= TO) begin
            kind = 1; end_x = d;
        end else begin
            kind = 2; end_x = TO;
        end
        r    = (kind == 0) ? 1 : ((kind <= 2) ? end_x + 2 : -1);
        last = (kind == 0) ? 3 : ((kind <= 2) ? r + 2 : end_x + 3);

        for (int j = 0; j <= last; j++) begin
            if (j > 0) begin
                @(posedge clk);
                #1;
                stb_ph = (tgt != 0) && (j <= end_x + 1);
                resp   = (j == r);
                check_eq("mprj_cyc", 32'(mprj_cyc_o), 32'(tgt == 1 && stb_ph));
                check_eq("mprj_stb", 32'(mprj_stb_o), 32'(tgt == 1 && stb_ph));
                check_eq("hk_cyc", 32'(hk_cyc_o), 32'(tgt == 2 && stb_ph));
                check_eq("hk_stb", 32'(hk_stb_o), 32'(tgt == 2 && stb_ph));
                check_eq("m_ack", 32'(m_ack_o), 32'(resp && kind == 1));
                check_eq("m_err", 32'(m_err_o), 32'(resp && kind != 1));
                check_eq("m_dat", m_dat_o, resp ? ((kind == 1) ? rdat : ERRD) : 32'h0);
                check_eq("timeout", 32'(timeout_o), 32'(resp && kind == 2));
                check_eq("busy", 32'(busy_o), 32'(stb_ph || resp));
                if (stb_ph) begin
                    check_eq("bus_adr", mprj_adr_o, adr);
                    check_eq("bus_dat", mprj_dat_o, wdat);
                    check_eq("bus_sel", 32'(mprj_sel_o), 32'(sel));
                    check_eq("bus_we", 32'(mprj_we_o), 32'(we));
                end
                if (kind == 4 && j == s + 2) begin
                    check_eq("rst_bus_adr", mprj_adr_o, 32'h0);
                    check_eq("rst_bus_dat", mprj_dat_o, 32'h0);
                end
            end
            if (j < last) begin
                rst   = (kind == 4 && j == s + 1);
                cyc_v = 1'b1;
                if (tgt != 0 && j >= a + 1) cyc_v = 1'b0;
                if (kind == 4 && j >= s + 1) cyc_v = 1'b0;
                if (kind <= 2 && j >= r + (hold ? 1 : 0)) cyc_v = 1'b0;
                m_cyc = cyc_v;
                m_stb = cyc_v;
                iena  = ien;
                if (j == 0) begin
                    m_adr = adr; m_wdat = wdat; m_sel = sel; m_we = we;
                end else begin
                    m_adr = $urandom; m_wdat = $urandom; m_sel = 4'($urandom); m_we = 1'($urandom);
                end
                md = $urandom;
                hd = $urandom;
                if (tgt == 1) begin
                    mprj_ack = (j == d + 1);
                    hk_ack   = 1'($urandom);
                    if (j == d + 1) md = rdat;
                end else if (tgt == 2) begin
                    hk_ack   = (j == d + 1);
                    mprj_ack = 1'($urandom);
                    if (j == d + 1) hd = rdat;
                end else begin
                    mprj_ack = 1'($urandom);
                    hk_ack   = 1'($urandom);
                end
                mprj_rdat = md;
                hk_rdat   = hd;
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] adr;
        int          cls, d, a, s;
        logic        ien, hold;

        // Reset held with a live mprj request: everything must stay quiet.
        rst = 1'b1; m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0; m_sel = 4'hF;
        m_adr = 32'h3000_0004; m_wdat = 32'h0; iena = 1'b1;
        mprj_ack = 1'b0; hk_ack = 1'b0; mprj_rdat = 32'h0; hk_rdat = 32'h0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check_eq("rst_mprj_stb", 32'(mprj_stb_o), 32'h0);
            check_eq("rst_hk_stb", 32'(hk_stb_o), 32'h0);
            check_eq("rst_ack", 32'(m_ack_o), 32'h0);
            check_eq("rst_err", 32'(m_err_o), 32'h0);
            check_eq("rst_dat", m_dat_o, 32'h0);
            check_eq("rst_busy", 32'(busy_o), 32'h0);
            check_eq("rst_adr", mprj_adr_o, 32'h0);
        end
        run_txn(32'h3000_0004, 1'b0, 32'h0, 4'hF, 1'b1, 1, NONE, NONE, 1'b0, 32'hCAFE_0001);

        run_txn(32'h3000_0010, 1'b0, 32'h0, 4'hF, 1'b1, 2, NONE, NONE, 1'b0, 32'h1234_5678);
        run_txn(32'h2600_0008, 1'b1, 32'hA5A5_0F0F, 4'b0011, 1'b1, 0, NONE, NONE, 1'b0, 32'h0BAD_F00D);
        run_txn(32'h3000_0000, 1'b0, 32'h0, 4'hF, 1'b0, 0, NONE, NONE, 1'b1, 32'h0);
        run_txn(32'h1000_0000, 1'b1, 32'h5555_AAAA, 4'hF, 1'b1, 0, NONE, NONE, 1'b0, 32'h0);
        run_txn(32'h2600_0100, 1'b0, 32'h0, 4'hF, 1'b1, NONE, NONE, NONE, 1'b0, 32'h0);
        run_txn(32'h2600_0104, 1'b0, 32'h0, 4'hF, 1'b1, TO, NONE, NONE, 1'b0, 32'h7777_8888);
        run_txn(32'h3000_0020, 1'b0, 32'h0, 4'hF, 1'b1, 2, 2, NONE, 1'b0, 32'h9999_0000);
        run_txn(32'h3000_0024, 1'b1, 32'h0102_0304, 4'hC, 1'b1, 1, NONE, NONE, 1'b1, 32'h4444_3333);
        run_txn(32'h3000_0028, 1'b0, 32'h0, 4'hF, 1'b1, 3, NONE, 1, 1'b0, 32'h0);

        for (int t = 0; t < 300; t++) begin
            cls = $urandom_range(0, 4);
            case (cls)
                0, 1:    adr = {4'h3, 28'($urandom)};
                2:       adr = {8'h26, 24'($urandom)};
                3:       adr = {8'h27, 24'($urandom)};
                default: adr = $urandom;
            endcase
            ien  = ($urandom_range(0, 3) != 0);
            d    = $urandom_range(0, 6);
            a    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : NONE;
            s    = ($urandom_range(0, 11) == 0) ? $urandom_range(0, 5) : NONE;
            hold = 1'($urandom);
            run_txn(adr, 1'($urandom), $urandom, 4'($urandom), ien, d, a, s, hold, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mgmt_wb_target_sequencer.md
Name: mgmt_wb_target_sequencer

Overview:
- Sits between the management core's single Wishbone master and the two exported Wishbone targets: the user project (mprj) and housekeeping (hk).
- Decodes each master cycle and forwards it to exactly one target with registered outputs.
- Returns ack or error to the master.
- Enforces a bus timeout, gates user-project access on mprj_wb_iena, and handles master abort.

Parameters:
- MPRJ_BASE, 32'h3000_0000, mprj address match value
- MPRJ_MASK, 32'hF000_0000, bits compared for mprj decode
- HK_BASE, 32'h2600_0000, hk address match value
- HK_MASK, 32'hFF00_0000, bits compared for hk decode
- TIMEOUT, 255, max target-wait cycles before error (1..2^TO_W-1)
- TO_W, 8, timeout counter width
- ERR_DATA, 32'hBADD_1E55, m_dat_o value on any error response

Ports:
- core_clk in 1 — clock
- core_rst in 1 — synchronous, active-high reset
- m_cyc_i, m_stb_i, m_we_i in 1 — master request
- m_sel_i in 4 — master byte selects
- m_adr_i, m_dat_i in 32 — master address / write data
- m_ack_o, m_err_o out 1 — master response pulses
- m_dat_o out 32 — master read data
- mprj_wb_iena in 1 — user wishbone enable
- mprj_cyc_o, mprj_stb_o, mprj_we_o out 1 — mprj request
- mprj_sel_o out 4 — mprj byte selects
- mprj_adr_o, mprj_dat_o out 32 — mprj address / write data
- mprj_ack_i in 1 — mprj ack
- mprj_dat_i in 32 — mprj read data
- hk_cyc_o, hk_stb_o out 1 — hk request (shares mprj_adr_o/dat_o/we_o/sel_o as common bus)
- hk_ack_i in 1 — hk ack
- hk_dat_i in 32 — hk read data
- busy_o out 1 — state != IDLE
- timeout_o out 1 — one-cycle pulse on timeout

Behaviour:
- All outputs are registered. Reset value of every output is 0.
- Reset anywhere, including mid-transaction, forces IDLE at the next edge. No ack/err is issued for the aborted transfer.
- States:
  - IDLE: waits for a request.
  - MPRJ: waits for the mprj target.
  - HK: waits for the hk target.
  - RESP: one-cycle response.
- Decode, in IDLE:
  - Request = m_cyc_i & m_stb_i & !m_ack_o & !m_err_o.
  - mprj_hit = (m_adr_i & MPRJ_MASK) == MPRJ_BASE. hk_hit is defined the same way with HK_BASE/HK_MASK. mprj_hit has priority if both match.
- Launch from IDLE on cycle N:
  - mprj_hit & mprj_wb_iena → MPRJ. At N+1: mprj_cyc_o = mprj_stb_o = 1; adr/dat/sel/we latched from the master at N.
  - hk_hit → HK. At N+1: hk_cyc_o = hk_stb_o = 1, with the same latching.
  - mprj_hit & !mprj_wb_iena, or no hit → RESP with error. At N+1: m_err_o = 1, m_dat_o = ERR_DATA. No target strobed.
- Target wait (MPRJ/HK):
  - Target ack sampled at cycle K → at K+1: target cyc/stb = 0, m_ack_o = 1 for one cycle, m_dat_o = target dat sampled at K (also for writes).
  - Minimum ack latency is 2 cycles (request N, ack N+2) for a target with combinational ack.
- Timeout:
  - Counter clears on launch and increments each cycle in MPRJ/HK without ack.
  - On the cycle the count equals TIMEOUT with no ack: next cycle target cyc/stb = 0, m_err_o = 1, m_dat_o = ERR_DATA, timeout_o = 1.
  - Ack in that same cycle wins: normal ack, no timeout.
- Master abort: m_cyc_i low during MPRJ/HK → next cycle target cyc/stb = 0, return to IDLE, no ack/err. A target ack arriving in the abort cycle is discarded.
- Target acks outside MPRJ/HK, and acks from the non-selected target, are ignored.
- RESP lasts exactly one cycle, then IDLE.
  - m_ack_o/m_err_o are never high together.
  - m_dat_o returns to 0 when m_ack_o/m_err_o drop.
  - A request still asserted in the response cycle is not relaunched. A new launch requires the request to be present in IDLE.
- The latched bus (mprj_adr_o/dat_o/sel/we) holds its value until the next launch.

Test Plan:
1. Reset with m_cyc_i=m_stb_i=1, adr 0x3000_0004 held → all outputs 0 while core_rst=1. Launch occurs on the first cycle after core_rst falls.
2. Read 0x3000_0010, mprj_wb_iena=1, mprj acks 3 cycles after stb with 0x1234_5678 → mprj_stb_o for 3 cycles; m_ack_o one cycle later with m_dat_o=0x1234_5678; hk_stb_o stays 0.
3. Write 0x2600_0008, dat 0xA5A5_0F0F, sel 4'b0011, hk acks combinationally → hk_stb_o 1 cycle; mprj_adr_o=0x2600_0008, mprj_dat_o=0xA5A5_0F0F, mprj_sel_o=3, mprj_we_o=1; m_ack_o at N+2.
4. Access 0x3000_0000 with mprj_wb_iena=0, and access 0x1000_0000 → m_err_o at N+1 with m_dat_o=0xBADD_1E55; no target strobe in either case.
5. TIMEOUT=4, hk never acks → hk_stb_o high 5 cycles, then m_err_o=1, timeout_o=1, m_dat_o=ERR_DATA. Repeat with the ack arriving on the terminal-count cycle → m_ack_o, no timeout_o.
6. Master drops m_cyc_i 2 cycles into an mprj wait, with mprj_ack_i asserted in the same cycle → mprj_stb_o drops next cycle, no m_ack_o/m_err_o, busy_o=0. The next request launches normally.
